data_memory_2lane: RTL and testbench
====================================

Name: data_memory_2lane

Overview:
- Parametrised, dual-lane data memory for the superscalar core's load/store path.
- Successor to the single-port word-only data RAM, with these additions:
  - two independent load/store lanes (lane 0 older, lane 1 younger in program order);
  - RISC-V byte, half and word access with sign/zero extension;
  - registered one-cycle read latency;
  - misalignment and out-of-range error reporting;
  - same-cycle intra-bundle store-to-load forwarding.
- Sits between the two execute-stage lanes and the writeback stage.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; word index = addr[31:2]
INIT_WORD0, 32'h11111111, time-zero content of word 0 (admin key); all other words time-zero 0

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous reset, active-low
req0  in  1  lane 0 access valid this cycle
we0  in  1  lane 0 store (1) / load (0)
funct3_0  in  3  lane 0 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr0  in  32  lane 0 byte address
wdata0  in  32  lane 0 store data, LSB-justified
req1, we1, funct3_1, addr1, wdata1  in  1/1/3/32/32  lane 1, same meaning
rvalid0  out  1  lane 0 response valid (loads and stores)
rdata0  out  32  lane 0 load result, extended; 0 for stores/errors
err0  out  1  lane 0 access faulted, valid with rvalid0
rvalid1, rdata1, err1  out  1/32/1  lane 1, same meaning

Behaviour:
- Reset, sampled when rst_n=0 at posedge:
  - rvalid0/1, rdata0/1, err0/1 <= 0.
  - No memory write occurs in that cycle, even with req/we high.
  - Memory contents are NOT cleared.
  - Reset held across several cycles keeps outputs at 0.
- Latency: request accepted in cycle N; rvalid/rdata/err registered and visible in cycle N+1.
  - No backpressure; both lanes accept every cycle.
  - Outputs hold their last value for one cycle only: when req=0 at cycle N, rvalid=0, rdata=0, err=0 in N+1.
- Error conditions per lane. Any error: err=1, rvalid=1, rdata=0, no write.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index >= DEPTH_WORDS.
  - funct3 not in {000,001,010,100,101}.
  - Store with funct3 of 100 or 101.
- Stores, at the posedge of cycle N:
  - B writes byte addr[1:0] from wdata[7:0].
  - H writes bytes {addr[1],0..1} from wdata[15:0].
  - W writes all 4 bytes.
  - Untouched bytes are preserved.
  - Response: rvalid=1, err=0, rdata=0.
- Loads: read the word and select the byte/half by addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W returns the word.
- Read-during-write:
  - A load in cycle N returns memory content from before cycle N's writes, except the forwarding case below.
  - A lane 0 load never sees a same-cycle lane 1 store.
- Forwarding: lane 1 load and lane 0 valid store to the same word in the same cycle.
  - Bytes written by lane 0 are merged into lane 1's read word, per byte, before extraction.
  - Non-overlapping bytes come from memory.
- Write conflict: both lanes store valid to the same word in the same cycle.
  - Per byte, lane 1 (younger) wins where both write.
  - Union of byte enables is written.
- Error interaction: an erroring store on either lane neither writes nor forwards.

Test Plan:
- Reset release, single-lane word:
  - Stimulus: after reset release, lane0 SW addr 0x10 data 0xDEADBEEF; next cycle lane0 LW 0x10.
  - Required: load response cycle after issue shows rvalid0=1, rdata0=0xDEADBEEF, err0=0; word 0 LW returns 0x11111111.
- Byte/half extension:
  - Stimulus: SB 0x21 data 0x80, then LB 0x21, LBU 0x21.
  - Required: 0xFFFFFF80, 0x00000080.
  - Stimulus: SH 0x22 data 0x8001, then LH 0x22 / LW 0x20.
  - Required: 0xFFFF8001 / 0x80018000.
- Errors:
  - Stimulus: LW 0x02, SH 0x03, LW 0x100 (DEPTH 64), funct3=011.
  - Required: each gives err=1, rvalid=1, rdata=0; subsequent LW 0x00 still 0x11111111.
- Same-cycle forwarding and conflict, word 0x40 preloaded 0x00000000:
  - Stimulus: lane0 SB 0x41 data 0xAB with lane1 LW 0x40.
  - Required: rdata1=0x0000AB00.
  - Stimulus: lane0 SW 0x40 0x11223344 with lane1 SB 0x40 0x55.
  - Required: later LW 0x40 = 0x11223355.
- Reset mid-operation:
  - Stimulus: SW 0x30 0xCAFEF00D, then rst_n=0 in the same cycle as SW 0x30 0x0BADBEEF, release, LW 0x30.
  - Required: outputs 0 during reset; load returns 0xCAFEF00D.

Source files
------------

// File: rtl/data_memory_2lane.sv
// Dual-lane data memory for the load/store path.
// Lane 0 is the older instruction of the bundle, lane 1 the younger.
// Each lane accepts a byte/half/word load or store every cycle. The response
// (rvalid/rdata/err) is registered and appears one cycle after the request.
// A lane 1 load sees bytes stored by lane 0 in the same cycle. When both lanes
// store to the same word, lane 1 bytes override lane 0 bytes.
module data_memory_2lane #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] INIT_WORD0  = 32'h11111111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [2:0]  funct3_0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [2:0]  funct3_1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        rvalid0,
    output logic [31:0] rdata0,
    output logic        err0,
    output logic        rvalid1,
    output logic [31:0] rdata1,
    output logic        err1
);

    // Width of the in-range word index taken from addr[IDXW+1:2].
    localparam int unsigned IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

    // Access size encoding found in funct3[1:0].
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Storage. Word 0 powers up holding the admin key; reset never clears it.
    logic [31:0] mem [DEPTH_WORDS] = '{0: INIT_WORD0, default: 32'h0};

    // ------------------------------------------------------------------
    // Helper functions shared by both lanes
    // ------------------------------------------------------------------

    // Any fault: illegal funct3, misalignment, out-of-range word, or a store
    // that asks for the unsigned (load-only) encodings.
    function automatic logic lane_fault(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr);
        logic illegal;
        logic misaligned;
        logic out_of_range;
        logic bad_store;
        illegal      = (f3 == 3'b011) || (f3[2] && f3[1]);
        misaligned   = ((f3[1:0] == SIZE_H) && addr[0]) ||
                       ((f3[1:0] == SIZE_W) && (addr[1:0] != 2'b00));
        out_of_range = (addr[31:2] >= DEPTH_LIMIT);
        bad_store    = we && f3[2];
        return illegal || misaligned || out_of_range || bad_store;
    endfunction

    // Byte lanes touched within the word.
    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << offset;
            SIZE_H:  be = offset[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated so every enabled byte lane carries the right byte.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SIZE_B:  lanes = {4{wdata[7:0]}};
            SIZE_H:  lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    // Pick the addressed byte/half out of the word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  offset,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        case (f3)
            3'b000:  result = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  result = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  result = {24'h0, shifted[7:0]};
            3'b101:  result = {16'h0, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Lane 0 decode
    // ------------------------------------------------------------------
    logic             fault0;
    logic             store0;
    logic             load0;
    logic [3:0]       be0;
    logic [31:0]      wlanes0;
    logic [IDXW-1:0]  idx0;
    logic [31:0]      word0;

    // Classify lane 0 and fetch its word (pre-write contents).
    always_comb begin
        fault0  = req0 && lane_fault(we0, funct3_0, addr0);
        store0  = req0 && we0 && !fault0;
        load0   = req0 && !we0 && !fault0;
        be0     = byte_enables(funct3_0[1:0], addr0[1:0]);
        wlanes0 = store_lanes(funct3_0[1:0], wdata0);
        idx0    = addr0[IDXW+1:2];
        word0   = 32'h0;
        if (load0) begin
            word0 = mem[idx0];
        end
    end

    // ------------------------------------------------------------------
    // Lane 1 decode
    // ------------------------------------------------------------------
    logic             fault1;
    logic             store1;
    logic             load1;
    logic [3:0]       be1;
    logic [31:0]      wlanes1;
    logic [IDXW-1:0]  idx1;
    logic [31:0]      word1_mem;
    logic [31:0]      word1;

    // Classify lane 1 and fetch its word (pre-write contents).
    always_comb begin
        fault1    = req1 && lane_fault(we1, funct3_1, addr1);
        store1    = req1 && we1 && !fault1;
        load1     = req1 && !we1 && !fault1;
        be1       = byte_enables(funct3_1[1:0], addr1[1:0]);
        wlanes1   = store_lanes(funct3_1[1:0], wdata1);
        idx1      = addr1[IDXW+1:2];
        word1_mem = 32'h0;
        if (load1) begin
            word1_mem = mem[idx1];
        end
    end

    // Merge bytes of a same-cycle lane 0 store into the lane 1 read word.
    // Lane 0 is older, so lane 1 must observe its effect; the reverse never
    // applies.
    always_comb begin
        word1 = word1_mem;
        if (load1 && store0 && (idx0 == idx1)) begin
            for (int b = 0; b < 4; b++) begin
                if (be0[b]) begin
                    word1[8*b +: 8] = wlanes0[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory write
    // ------------------------------------------------------------------

    // Lane 0 bytes are written first so that lane 1 bytes win on overlap;
    // bytes enabled by only one lane are still written.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (store0) begin
                for (int b = 0; b < 4; b++) begin
                    if (be0[b]) begin
                        mem[idx0][8*b +: 8] <= wlanes0[8*b +: 8];
                    end
                end
            end
            if (store1) begin
                for (int b = 0; b < 4; b++) begin
                    if (be1[b]) begin
                        mem[idx1][8*b +: 8] <= wlanes1[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered responses
    // ------------------------------------------------------------------

    // Lane 0 response: valid for every request, data only for good loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rdata0  <= 32'h0;
            err0    <= 1'b0;
        end else begin
            rvalid0 <= req0;
            err0    <= fault0;
            rdata0  <= load0 ? load_extract(funct3_0, addr0[1:0], word0) : 32'h0;
        end
    end

    // Lane 1 response: same rules, using the forwarded word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid1 <= 1'b0;
            rdata1  <= 32'h0;
            err1    <= 1'b0;
        end else begin
            rvalid1 <= req1;
            err1    <= fault1;
            rdata1  <= load1 ? load_extract(funct3_1, addr1[1:0], word1) : 32'h0;
        end
    end

endmodule

// File: tb/tb_data_memory_2lane.sv
// Testbench for data_memory_2lane: a byte-array reference model predicts each
// response when the request is issued; a monitor checks DUT outputs.
module tb_data_memory_2lane;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [2:0]  funct3_0, funct3_1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        rvalid0, err0, rvalid1, err1;
    logic [31:0] rdata0, rdata1;

    data_memory_2lane #(.DEPTH_WORDS(DEPTH), .INIT_WORD0(32'h11111111)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .funct3_0(funct3_0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .funct3_1(funct3_1), .addr1(addr1), .wdata1(wdata1),
        .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;

    // Reference memory, one entry per byte address.
    logic [7:0] ref_mem [DEPTH*4];

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1;
        sz = size_of(f3);
        if ((a % sz) != 0) return 1;
        if ((a >> 2) >= DEPTH) return 1;
        if (we && f3 >= 3'd4) return 1;
        return 0;
    endfunction

    // Little-endian load of sz bytes, optionally overlaid with an older store.
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                             input bit fwd, input logic [31:0] fa,
                                             input int fsz, input logic [31:0] fd);
        int          sz;
        logic [31:0] v;
        logic [31:0] t;
        logic [7:0]  b;
        sz = size_of(f3);
        v  = 0;
        for (int i = 0; i < sz; i++) begin
            if (fwd && (a + i >= fa) && (a + i < fa + fsz)) begin
                t = fd >> (8 * (a + i - fa));
                b = t[7:0];
            end else begin
                b = ref_mem[a + i];
            end
            v = v | (32'(b) << (8 * i));
        end
        if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) begin
            v = v | ~((32'd1 << (8 * sz)) - 1);
        end
        return v;
    endfunction

    function automatic void store_bytes(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] d);
        logic [31:0] t;
        for (int i = 0; i < size_of(f3); i++) begin
            t = d >> (8 * i);
            ref_mem[a + i] = t[7:0];
        end
    endfunction

    // One clock cycle of stimulus, with the model's prediction queued.
    task automatic cyc(input logic rst,
                       input logic r0, input logic w0, input logic [2:0] f0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [2:0] f1,
                       input logic [31:0] a1, input logic [31:0] d1);
        bit   e0, e1, s0, s1;
        exp_t x;
        @(negedge clk);
        rst_n = rst;
        req0 = r0; we0 = w0; funct3_0 = f0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; funct3_1 = f1; addr1 = a1; wdata1 = d1;
        if (rst) begin
            e0 = r0 && is_err(w0, f0, a0);
            e1 = r1 && is_err(w1, f1, a1);
            s0 = r0 && w0 && !e0;
            s1 = r1 && w1 && !e1;
            if (r0) begin
                x.err  = e0;
                x.data = (!w0 && !e0) ? load_val(f0, a0, 0, 0, 0, 0) : 32'h0;
                q0.push_back(x);
            end
            if (r1) begin
                x.err  = e1;
                x.data = (!w1 && !e1) ? load_val(f1, a1, s0, a0, size_of(f0), d0) : 32'h0;
                q1.push_back(x);
            end
            if (s0) store_bytes(f0, a0, d0);
            if (s1) store_bytes(f1, a1, d1);
        end
    endtask

    task automatic op0(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        cyc(1, 1, w, f, a, d, 0, 0, 3'd0, 0, 0);
    endtask

    task automatic idle(input logic rst);
        cyc(rst, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0);
    endtask

    function automatic logic [2:0] rand_f3();
        logic [2:0] pick [5];
        pick = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        if ($urandom_range(0, 9) == 0) return 3'($urandom_range(0, 7));
        return pick[$urandom_range(0, 4)];
    endfunction

    function automatic logic [31:0] rand_addr(input logic [2:0] f3);
        logic [31:0] a;
        int k;
        k = $urandom_range(0, 19);
        if (k == 0)      a = $urandom;
        else if (k == 1) a = 32'((DEPTH + $urandom_range(0, 3)) * 4 + $urandom_range(0, 3));
        else             a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 2) != 0) a = a & ~32'(size_of(f3) - 1);
        return a;
    endfunction

    // Compare one lane's outputs against the queue head when it responds,
    // otherwise require quiet outputs.
    task automatic check_lane(input int lane, input logic v, input logic [31:0] d,
                              input logic e);
        exp_t x;
        n_cmp++;
        if (v) begin
            if ((lane == 0 ? q0.size() : q1.size()) == 0) begin
                n_bad++;
                $display("FAIL lane%0d unexpected_rvalid got rdata=%h err=%0d required none", lane, d, e);
            end else begin
                x = (lane == 0) ? q0.pop_front() : q1.pop_front();
                if (d !== x.data || e !== x.err) begin
                    n_bad++;
                    $display("FAIL lane%0d response got rdata=%h err=%0d required rdata=%h err=%0d @%0t",
                             lane, d, e, x.data, x.err, $time);
                end
            end
        end else if (d !== 32'h0 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL lane%0d idle_outputs got rdata=%h err=%0d required 0/0", lane, d, e);
        end
    endtask

    // Monitor: responses are sampled on the falling edge, away from the
    // clock edge that updates them.
    initial begin
        while (!done) begin
            @(negedge clk);
            if (!done) begin
                check_lane(0, rvalid0, rdata0, err0);
                check_lane(1, rvalid1, rdata1, err1);
            end
        end
    end

    // Stimulus.
    initial begin
        logic        r0, w0, r1, w1;
        logic [2:0]  f0, f1;
        logic [31:0] a0, a1;

        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) ref_mem[i] = 8'h11;

        rst_n = 0;
        req0 = 0; we0 = 0; funct3_0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; funct3_1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) idle(0);

        // Word store/load and the admin key.
        op0(1, 3'd2, 32'h10, 32'hDEADBEEF);
        op0(0, 3'd2, 32'h10, 0);
        op0(0, 3'd2, 32'h00, 0);

        // Byte/half sign and zero extension.
        op0(1, 3'd0, 32'h21, 32'h80);
        op0(0, 3'd0, 32'h21, 0);
        op0(0, 3'd4, 32'h21, 0);
        op0(1, 3'd1, 32'h22, 32'h8001);
        op0(0, 3'd1, 32'h22, 0);
        op0(0, 3'd2, 32'h20, 0);

        // Faults, then confirm nothing was disturbed.
        op0(0, 3'd2, 32'h02, 0);
        op0(1, 3'd1, 32'h03, 32'hFFFF);
        op0(0, 3'd2, 32'h100, 0);
        op0(0, 3'd3, 32'h00, 0);
        op0(1, 3'd4, 32'h00, 32'hFF);
        op0(0, 3'd2, 32'h00, 0);

        // Same-cycle forwarding and write conflict on word 0x40.
        op0(1, 3'd2, 32'h40, 32'h0);
        cyc(1, 1, 1, 3'd0, 32'h41, 32'hAB, 1, 0, 3'd2, 32'h40, 0);
        cyc(1, 1, 1, 3'd2, 32'h40, 32'h11223344, 1, 1, 3'd0, 32'h40, 32'h55);
        op0(0, 3'd2, 32'h40, 0);
        // Lane 0 load must not see a same-cycle lane 1 store.
        cyc(1, 1, 0, 3'd2, 32'h40, 0, 1, 1, 3'd2, 32'h40, 32'h99999999);
        op0(0, 3'd2, 32'h40, 0);

        // Reset in the middle of traffic: the store under reset is dropped.
        op0(1, 3'd2, 32'h30, 32'hCAFEF00D);
        cyc(0, 1, 1, 3'd2, 32'h30, 32'h0BADBEEF, 1, 0, 3'd2, 32'h30, 0);
        idle(0);
        op0(0, 3'd2, 32'h30, 0);

        // Randomized dual-lane traffic focused on a few words.
        for (int n = 0; n < 600; n++) begin
            r0 = ($urandom_range(0, 4) != 0);
            r1 = ($urandom_range(0, 4) != 0);
            w0 = $urandom_range(0, 1);
            w1 = $urandom_range(0, 1);
            f0 = rand_f3();
            f1 = rand_f3();
            a0 = rand_addr(f0);
            a1 = rand_addr(f1);
            if ($urandom_range(0, 9) < 4) a1 = {a0[31:2], a1[1:0]};
            cyc(($urandom_range(0, 49) != 0), r0, w0, f0, a0, $urandom, r1, w1, f1, a1, $urandom);
        end

        idle(1);
        idle(1);
        @(negedge clk);
        done = 1;

        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL missing_responses got lane0=%0d lane1=%0d pending required 0", q0.size(), q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
